// File: rtl/fetch_bus_if_pkg.sv
// Shared definitions for the instruction-fetch bus interface: the FSM state
// type, default word widths and the instruction used when a fetch is discarded.
package fetch_bus_if_pkg;

  localparam int FETCH_ADDR_W = 30;
  localparam int FETCH_DATA_W = 32;

  // addi x0, x0, 0 -- fed to the IF register whenever a fetched word is dropped
  localparam logic [31:0] ISA_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    HOLD
  } fetch_state_t;

endpackage

// File: rtl/fetch_bus_if.sv
// Instruction-fetch bus interface: turns an IF-stage fetch into one bus read
// transaction and holds the returned word while the pipeline is stalled.
module fetch_bus_if
  import fetch_bus_if_pkg::*;
#(
  parameter int ADDR_W = FETCH_ADDR_W,
  parameter int DATA_W = FETCH_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              req_en,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              bus_req,
  input  logic              bus_grnt,
  output logic              bus_as,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_rdy,
  input  logic [DATA_W-1:0] bus_rd_data
);

  localparam logic [DATA_W-1:0] NOP_WORD = DATA_W'(ISA_NOP);

  fetch_state_t      state;
  fetch_state_t      state_next;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_next;
  logic              hold_load;
  logic              addr_load;
  logic              discard_q;
  logic              discard_next;
  logic              first_q;
  logic              first_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      hold_q    <= NOP_WORD;
      discard_q <= 1'b0;
      first_q   <= 1'b0;
    end else begin
      state     <= state_next;
      discard_q <= discard_next;
      first_q   <= first_next;
      if (addr_load) begin
        addr_q <= addr;
      end
      if (hold_load) begin
        hold_q <= hold_next;
      end
    end
  end

  // A flush while the bus read is in flight cannot abort it; the word is
  // instead replaced by a NOP when it arrives (discard_q or a same-cycle flush).
  always_comb begin
    state_next   = state;
    busy         = 1'b0;
    bus_req      = 1'b0;
    bus_as       = 1'b0;
    rd_data      = hold_q;
    addr_load    = 1'b0;
    hold_load    = 1'b0;
    hold_next    = hold_q;
    discard_next = discard_q;
    first_next   = 1'b0;

    unique case (state)
      IDLE: begin
        if (req_en && !flush) begin
          busy       = 1'b1;
          addr_load  = 1'b1;
          state_next = REQ;
        end
      end

      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_grnt) begin
          state_next   = ACCESS;
          discard_next = flush;
          first_next   = 1'b1;
        end else if (flush) begin
          state_next = IDLE;
        end
      end

      ACCESS: begin
        bus_req = 1'b1;
        bus_as  = first_q;
        if (bus_rdy) begin
          hold_load    = 1'b1;
          discard_next = 1'b0;
          if (discard_q || flush) begin
            rd_data    = NOP_WORD;
            hold_next  = NOP_WORD;
            state_next = IDLE;
          end else begin
            rd_data    = bus_rd_data;
            hold_next  = bus_rd_data;
            state_next = stall ? HOLD : IDLE;
          end
        end else begin
          busy = 1'b1;
          if (flush) begin
            discard_next = 1'b1;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          hold_load  = 1'b1;
          hold_next  = NOP_WORD;
          state_next = IDLE;
        end else if (!stall) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus_rw   = 1'b1;
  assign bus_addr = addr_q;

endmodule
